div_share_ctrl: RTL and testbench

- Sequential controller that shares one iterative restoring divider between two requesters (port 0, port 1).
- Arbitrates requests round-robin, runs the shift/subtract/restore loop one quotient bit per clock, and returns quotient, remainder and requester tag over a valid/ready response channel.
- Sits between the ALU issue logic and the divider datapath. It replaces the one-shot combinational divide with an N-cycle multi-cycle unit.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_iter_step.sv | 31 +++
 rtl/div_share_ctrl.sv | 125 ++++++++++++
 tb/tb_div_share_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the shared restoring-divider controller.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int unsigned DIV_N = 32;

  // Counter width able to hold the values 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract, restore on borrow, and shift the quotient bit into num.
module div_iter_step
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic [N:0]   rem,
  input  logic [N-1:0] num,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_nxt,
  output logic [N-1:0] num_nxt
);

  logic [N:0] shifted;
  logic [N:0] diff;
  logic       qbit;
  logic       unused_msb;

  // The running remainder is always below the divisor, so its MSB is zero here.
  assign unused_msb = rem[N];

  always_comb begin
    shifted = {rem[N-1:0], num[N-1]};
    diff    = shifted - {1'b0, divisor};
    qbit    = ~diff[N];
    rem_nxt = qbit ? diff : shifted;
    num_nxt = {num[N-2:0], qbit};
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Two-port round-robin front end sharing one N-cycle restoring divider,
// with a registered valid/ready response channel.
module div_share_ctrl
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_dividend,
  input  logic [N-1:0] req0_divisor,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_dividend,
  input  logic [N-1:0] req1_divisor,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_quotient,
  output logic [N-1:0] rsp_remainder,
  output logic         rsp_dz
);

  localparam int unsigned CNT_W = cnt_w(N);

  state_t             state;
  logic               last_grant;
  logic [N:0]         rem_q;
  logic [N-1:0]       num_q;
  logic [N-1:0]       div_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [N:0]         rem_nxt;
  logic [N-1:0]       num_nxt;
  logic               grant1;
  logic               accept;
  logic [N-1:0]       sel_dividend;
  logic [N-1:0]       sel_divisor;

  // Port 1 wins when it alone is valid, or on a tie (both or neither) when
  // port 0 was granted last.
  always_comb begin
    grant1       = (req1_valid && !req0_valid) ||
                   (!(req0_valid ^ req1_valid) && !last_grant);
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    if (state == IDLE && !reset) begin
      req1_ready = grant1;
      req0_ready = ~grant1;
    end
    accept       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    sel_dividend = grant1 ? req1_dividend : req0_dividend;
    sel_divisor  = grant1 ? req1_divisor  : req0_divisor;
  end

  div_iter_step #(
    .N(N)
  ) u_step (
    .rem     (rem_q),
    .num     (num_q),
    .divisor (div_q),
    .rem_nxt (rem_nxt),
    .num_nxt (num_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      rem_q         <= '0;
      num_q         <= '0;
      div_q         <= '0;
      cnt_q         <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_dz        <= 1'b0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant1;
            rsp_id     <= grant1;
            num_q      <= sel_dividend;
            div_q      <= sel_divisor;
            rem_q      <= '0;
            cnt_q      <= '0;
            state      <= (sel_divisor == '0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          rem_q <= rem_nxt;
          num_q <= num_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          // The last iteration's result goes straight to the response
          // registers so rsp_valid rises exactly N edges after acceptance.
          if (cnt_q == CNT_W'(N - 1)) begin
            state         <= DONE;
            rsp_valid     <= 1'b1;
            rsp_quotient  <= num_nxt;
            rsp_remainder <= rem_nxt[N-1:0];
            rsp_dz        <= 1'b0;
          end
        end
        DONE: begin
          // Entering DONE with rsp_valid low only happens for a zero divisor.
          if (!rsp_valid) begin
            rsp_valid     <= 1'b1;
            rsp_dz        <= 1'b1;
            rsp_quotient  <= '1;
            rsp_remainder <= num_q;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl: latency, arbitration, divide-by-zero,
// edge operands, response backpressure and mid-divide reset.
module tb_div_share_ctrl;

  localparam int unsigned N = 32;

  logic         clk;
  logic         reset;
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_dividend;
  logic [N-1:0] req0_divisor;
  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_dividend;
  logic [N-1:0] req1_divisor;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [N-1:0] rsp_quotient;
  logic [N-1:0] rsp_remainder;
  logic         rsp_dz;

  int checks = 0;
  int errors = 0;

  div_share_ctrl #(
    .N(N)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_dividend (req0_dividend),
    .req0_divisor  (req0_divisor),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_dividend (req1_dividend),
    .req1_divisor  (req1_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_dz        (rsp_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for its grant and result, and handshake it
  // (rsp_ready must already be high).
  task automatic run_one(input string tag, input bit port,
                         input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] eq, input logic [N-1:0] er,
                         input bit edz, input int exp_lat);
    int n;
    if (port) begin
      req1_valid = 1'b1; req1_dividend = a; req1_divisor = b;
    end else begin
      req0_valid = 1'b1; req0_dividend = a; req0_divisor = b;
    end
    #1;
    n = 0;
    while (!(port ? req1_ready : req0_ready) && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_grant"}, port ? req1_ready : req0_ready, 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk({tag, "_busy_readys"}, {req0_ready, req1_ready}, 2'b00);
    n = 0;
    while (!rsp_valid && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_quot"}, rsp_quotient, eq);
    chk({tag, "_rem"}, rsp_remainder, er);
    chk({tag, "_id"}, rsp_id, port);
    chk({tag, "_dz"}, rsp_dz, edz);
    step();
    chk({tag, "_after_hs"}, rsp_valid, 0);
  endtask

  initial begin
    int n;
    int seen;
    reset         = 1'b0;
    req0_valid    = 1'b0;
    req0_dividend = '0;
    req0_divisor  = '0;
    req1_valid    = 1'b0;
    req1_dividend = '0;
    req1_divisor  = '0;
    rsp_ready     = 1'b1;

    #1 reset = 1'b1;
    #1;
    chk("reset_state",
        {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_dz, rsp_quotient, rsp_remainder},
        '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("idle_pref_port0", {req0_ready, req1_ready}, 2'b10);
    req1_valid = 1'b1;
    #1;
    chk("idle_only_port1", {req0_ready, req1_ready}, 2'b01);
    req1_valid = 1'b0;
    #1;

    run_one("t14_3", 1'b0, 32'd14, 32'd3, 32'd4, 32'd2, 1'b0, N);
    run_one("dz333", 1'b1, 32'd333, 32'd0, 32'hFFFF_FFFF, 32'd333, 1'b1, 1);

    // Both ports valid continuously: grants alternate starting with port 0.
    req0_valid = 1'b1; req0_dividend = 32'd5001; req0_divisor = 32'd5;
    req1_valid = 1'b1; req1_dividend = 32'd900;  req1_divisor = 32'd9;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 200) begin
        step();
        n++;
      end
      chk($sformatf("rr_grant%0d", k), {req0_ready, req1_ready},
          (k % 2 == 1) ? 2'b01 : 2'b10);
      n = 0;
      while (!rsp_valid && n < 200) begin
        step();
        n++;
      end
      chk($sformatf("rr_valid%0d", k), rsp_valid, 1);
      chk($sformatf("rr_id%0d", k), rsp_id, k % 2);
      chk($sformatf("rr_quot%0d", k), rsp_quotient, (k % 2 == 1) ? 32'd100 : 32'd1000);
      chk($sformatf("rr_rem%0d", k), rsp_remainder, (k % 2 == 1) ? 32'd0 : 32'd1);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;

    run_one("msb_div", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, N);
    run_one("t7_9", 1'b0, 32'd7, 32'd9, 32'd0, 32'd7, 1'b0, N);
    run_one("t9_1", 1'b0, 32'd9, 32'd1, 32'd9, 32'd0, 1'b0, N);

    // Backpressure: result held for 10 cycles while a second port 0 request waits.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_dividend = 32'd100; req0_divisor = 32'd7;
    #1;
    chk("bp_grant", req0_ready, 1);
    step();
    req0_dividend = 32'd50;
    req0_divisor  = 32'd6;
    n = 0;
    while (!rsp_valid && n < 200) begin
      step();
      n++;
    end
    chk("bp_latency", n, N);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp_hold%0d", i),
          {rsp_valid, req0_ready, req1_ready, rsp_id, rsp_dz, rsp_quotient, rsp_remainder},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd14, 32'd2});
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_after_hs", {rsp_valid, req0_ready}, 2'b01);
    step();
    req0_valid = 1'b0;
    #1;
    chk("bp_pending_accepted", {req0_ready, req1_ready}, 2'b00);
    n = 0;
    while (!rsp_valid && n < 200) begin
      step();
      n++;
    end
    chk("bp2_latency", n, N);
    chk("bp2_result", {rsp_id, rsp_dz, rsp_quotient, rsp_remainder},
        {1'b0, 1'b0, 32'd8, 32'd2});
    step();

    // Reset five clocks into a divide abandons it.
    req0_valid = 1'b1; req0_dividend = 32'd1000; req0_divisor = 32'd10;
    #1;
    chk("rst_grant", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    #1;
    chk("rst_mid_outputs",
        {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_dz, rsp_quotient, rsp_remainder},
        '0);
    repeat (2) step();
    reset = 1'b0;
    #1;
    chk("rst_release_pref", {req0_ready, req1_ready}, 2'b10);
    seen = 0;
    for (int i = 0; i < int'(N) + 5; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    chk("rst_no_rsp", seen, 0);
    run_one("post_rst", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, N);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
